tlb_core: RTL

TLB storage array that sits directly behind the address-translation unit, which presents virtual addresses and consumes the lookup results.
- Provides two combinational search ports: port 0 for fetch, port 1 for memory access, tlbsrch and invtlb.
- Provides one synchronous write port (tlbwr/tlbfill) and one combinational read port (tlbrd).
- Performs invtlb invalidation using port-1 search keys.
- Provides a free-running fill-index generator for tlbfill.

---
 rtl/tlb_pkg.sv | 43 ++++
 rtl/tlb_core_if.sv | 79 +++++++
 rtl/tlb_search_port.sv | 55 +++++
 rtl/tlb_core.sv | 125 ++++++++++++
 4 files changed

// File: rtl/tlb_pkg.sv
// Shared TLB types and constants: page sizes, invtlb opcodes, entry layout
// and the VPPN compare rule.
package tlb_pkg;

   localparam logic [5:0] PS_4K = 6'd12;
   localparam logic [5:0] PS_2M = 6'd21;

   localparam logic [4:0] INV_ALL0     = 5'd0;
   localparam logic [4:0] INV_ALL1     = 5'd1;
   localparam logic [4:0] INV_G        = 5'd2;
   localparam logic [4:0] INV_NG       = 5'd3;
   localparam logic [4:0] INV_ASID     = 5'd4;
   localparam logic [4:0] INV_ASID_VA  = 5'd5;
   localparam logic [4:0] INV_GASID_VA = 5'd6;

   typedef struct packed {
      logic [19:0] ppn;
      logic [1:0]  plv;
      logic [1:0]  mat;
      logic        d;
      logic        v;
   } tlb_page_t;

   typedef struct packed {
      logic        e;
      logic        g;
      logic [18:0] vppn;
      logic [5:0]  ps;
      logic [9:0]  asid;
      tlb_page_t   p0;
      tlb_page_t   p1;
   } tlb_entry_t;

   // A 2M entry covers 512 4K VPPNs, so its low 9 VPPN bits are don't-care.
   function automatic logic vppn_match(input tlb_entry_t ent, input logic [18:0] vppn);
      logic w_hi;
      logic w_lo;
      w_hi = (ent.vppn[18:9] == vppn[18:9]);
      w_lo = (ent.vppn[8:0] == vppn[8:0]);
      return w_hi && ((ent.ps == PS_2M) || w_lo);
   endfunction

endpackage

// File: rtl/tlb_core_if.sv
// Bus between the address-translation unit (master) and the TLB array
// (slave): two search ports, invtlb control, write, read and fill index.
interface tlb_core_if #(parameter int TLBNUM = 16);
   localparam int IDXW = $clog2(TLBNUM);

   logic [18:0]     s0_vppn;
   logic            s0_va_bit12;
   logic [9:0]      s0_asid;
   logic            s0_found;
   logic [IDXW-1:0] s0_index;
   logic [19:0]     s0_ppn;
   logic [5:0]      s0_ps;
   logic [1:0]      s0_plv;
   logic [1:0]      s0_mat;
   logic            s0_d;
   logic            s0_v;

   logic [18:0]     s1_vppn;
   logic            s1_va_bit12;
   logic [9:0]      s1_asid;
   logic            s1_found;
   logic [IDXW-1:0] s1_index;
   logic [19:0]     s1_ppn;
   logic [5:0]      s1_ps;
   logic [1:0]      s1_plv;
   logic [1:0]      s1_mat;
   logic            s1_d;
   logic            s1_v;

   logic            invtlb_valid;
   logic [4:0]      invtlb_op;

   logic            we;
   logic [IDXW-1:0] w_index;
   logic            w_e, w_g;
   logic [18:0]     w_vppn;
   logic [5:0]      w_ps;
   logic [9:0]      w_asid;
   logic [19:0]     w_ppn0, w_ppn1;
   logic [1:0]      w_plv0, w_mat0, w_plv1, w_mat1;
   logic            w_d0, w_v0, w_d1, w_v1;

   logic [IDXW-1:0] r_index;
   logic            r_e, r_g;
   logic [18:0]     r_vppn;
   logic [5:0]      r_ps;
   logic [9:0]      r_asid;
   logic [19:0]     r_ppn0, r_ppn1;
   logic [1:0]      r_plv0, r_mat0, r_plv1, r_mat1;
   logic            r_d0, r_v0, r_d1, r_v1;

   logic [IDXW-1:0] fill_index;

   modport master (
      output s0_vppn, s0_va_bit12, s0_asid, s1_vppn, s1_va_bit12, s1_asid,
      output invtlb_valid, invtlb_op,
      output we, w_index, w_e, w_g, w_vppn, w_ps, w_asid,
      output w_ppn0, w_plv0, w_mat0, w_d0, w_v0, w_ppn1, w_plv1, w_mat1, w_d1, w_v1,
      output r_index,
      input  s0_found, s0_index, s0_ppn, s0_ps, s0_plv, s0_mat, s0_d, s0_v,
      input  s1_found, s1_index, s1_ppn, s1_ps, s1_plv, s1_mat, s1_d, s1_v,
      input  r_e, r_g, r_vppn, r_ps, r_asid,
      input  r_ppn0, r_plv0, r_mat0, r_d0, r_v0, r_ppn1, r_plv1, r_mat1, r_d1, r_v1,
      input  fill_index
   );

   modport slave (
      input  s0_vppn, s0_va_bit12, s0_asid, s1_vppn, s1_va_bit12, s1_asid,
      input  invtlb_valid, invtlb_op,
      input  we, w_index, w_e, w_g, w_vppn, w_ps, w_asid,
      input  w_ppn0, w_plv0, w_mat0, w_d0, w_v0, w_ppn1, w_plv1, w_mat1, w_d1, w_v1,
      input  r_index,
      output s0_found, s0_index, s0_ppn, s0_ps, s0_plv, s0_mat, s0_d, s0_v,
      output s1_found, s1_index, s1_ppn, s1_ps, s1_plv, s1_mat, s1_d, s1_v,
      output r_e, r_g, r_vppn, r_ps, r_asid,
      output r_ppn0, r_plv0, r_mat0, r_d0, r_v0, r_ppn1, r_plv1, r_mat1, r_d1, r_v1,
      output fill_index
   );
endinterface

// File: rtl/tlb_search_port.sv
// One combinational TLB search port: per-entry match, lowest-index priority
// select and odd/even page pick.
module tlb_search_port
   import tlb_pkg::*;
#(
   parameter int TLBNUM = 16
) (
   input  tlb_entry_t                   i_entries [TLBNUM],
   input  logic [18:0]                  i_vppn,
   input  logic                         i_va_bit12,
   input  logic [9:0]                   i_asid,
   output logic [TLBNUM-1:0]            o_match,
   output logic                         o_found,
   output logic [$clog2(TLBNUM)-1:0]    o_index,
   output tlb_page_t                    o_page,
   output logic [5:0]                   o_ps
);
   localparam int IDXW = $clog2(TLBNUM);

   tlb_entry_t w_sel;
   logic       w_odd;

   always_comb begin
      o_match = '0;
      for (int i = 0; i < TLBNUM; i++) begin
         o_match[i] = i_entries[i].e &&
                      (i_entries[i].g || (i_entries[i].asid == i_asid)) &&
                      vppn_match(i_entries[i], i_vppn);
      end
   end

   // Scanning downward leaves the lowest matching index as the winner.
   always_comb begin
      o_found = 1'b0;
      o_index = '0;
      for (int i = TLBNUM - 1; i >= 0; i--) begin
         if (o_match[i]) begin
            o_found = 1'b1;
            o_index = IDXW'(i);
         end
      end
   end

   always_comb begin
      w_sel  = i_entries[o_index];
      w_odd  = (w_sel.ps == PS_2M) ? i_vppn[8] : i_va_bit12;
      o_page = '0;
      o_ps   = '0;
      if (o_found) begin
         o_page = w_odd ? w_sel.p1 : w_sel.p0;
         o_ps   = w_sel.ps;
      end
   end

endmodule

// File: rtl/tlb_core.sv
// TLB storage array: two search ports, synchronous write, combinational
// read, invtlb invalidation and a free-running tlbfill index.
module tlb_core
   import tlb_pkg::*;
#(
   parameter int TLBNUM = 16
) (
   input  logic       clk,
   input  logic       reset,
   tlb_core_if.slave  bus
);
   localparam int IDXW = $clog2(TLBNUM);

   tlb_entry_t      r_tlb [TLBNUM];
   logic [IDXW-1:0] r_fill;

   logic [TLBNUM-1:0] w_s0_match, w_s1_match, w_inv;
   logic              w_s0_found, w_s1_found;
   logic [IDXW-1:0]   w_s0_index, w_s1_index;
   tlb_page_t         w_s0_page, w_s1_page;
   logic [5:0]        w_s0_ps, w_s1_ps;
   tlb_entry_t        w_wr_ent, w_rd_ent;

   tlb_search_port #(.TLBNUM(TLBNUM)) u_s0 (
      .i_entries (r_tlb),
      .i_vppn    (bus.s0_vppn),
      .i_va_bit12(bus.s0_va_bit12),
      .i_asid    (bus.s0_asid),
      .o_match   (w_s0_match),
      .o_found   (w_s0_found),
      .o_index   (w_s0_index),
      .o_page    (w_s0_page),
      .o_ps      (w_s0_ps)
   );

   tlb_search_port #(.TLBNUM(TLBNUM)) u_s1 (
      .i_entries (r_tlb),
      .i_vppn    (bus.s1_vppn),
      .i_va_bit12(bus.s1_va_bit12),
      .i_asid    (bus.s1_asid),
      .o_match   (w_s1_match),
      .o_found   (w_s1_found),
      .o_index   (w_s1_index),
      .o_page    (w_s1_page),
      .o_ps      (w_s1_ps)
   );

   // Ops 5/6 reuse port 1's match vector; for g=0 it already implies the ASID compare.
   always_comb begin
      w_inv = '0;
      for (int i = 0; i < TLBNUM; i++) begin
         case (bus.invtlb_op)
            INV_ALL0, INV_ALL1: w_inv[i] = 1'b1;
            INV_G:              w_inv[i] = r_tlb[i].g;
            INV_NG:             w_inv[i] = !r_tlb[i].g;
            INV_ASID:           w_inv[i] = !r_tlb[i].g && (r_tlb[i].asid == bus.s1_asid);
            INV_ASID_VA:        w_inv[i] = !r_tlb[i].g && w_s1_match[i];
            INV_GASID_VA:       w_inv[i] = w_s1_match[i];
            default:            w_inv[i] = 1'b0;
         endcase
      end
   end

   always_comb begin
      w_wr_ent.e    = bus.w_e;
      w_wr_ent.g    = bus.w_g;
      w_wr_ent.vppn = bus.w_vppn;
      w_wr_ent.ps   = bus.w_ps;
      w_wr_ent.asid = bus.w_asid;
      w_wr_ent.p0   = '{ppn: bus.w_ppn0, plv: bus.w_plv0, mat: bus.w_mat0, d: bus.w_d0, v: bus.w_v0};
      w_wr_ent.p1   = '{ppn: bus.w_ppn1, plv: bus.w_plv1, mat: bus.w_mat1, d: bus.w_d1, v: bus.w_v1};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < TLBNUM; i++) r_tlb[i] <= '0;
         r_fill <= '0;
      end else begin
         r_fill <= r_fill + 1'b1;
         for (int i = 0; i < TLBNUM; i++) begin
            if (bus.we && (bus.w_index == IDXW'(i))) r_tlb[i] <= w_wr_ent;
            else if (bus.invtlb_valid && w_inv[i])   r_tlb[i].e <= 1'b0;
         end
      end
   end

   assign w_rd_ent = r_tlb[bus.r_index];

   assign bus.s0_found = w_s0_found;
   assign bus.s0_index = w_s0_index;
   assign bus.s0_ppn   = w_s0_page.ppn;
   assign bus.s0_ps    = w_s0_ps;
   assign bus.s0_plv   = w_s0_page.plv;
   assign bus.s0_mat   = w_s0_page.mat;
   assign bus.s0_d     = w_s0_page.d;
   assign bus.s0_v     = w_s0_page.v;

   assign bus.s1_found = w_s1_found;
   assign bus.s1_index = w_s1_index;
   assign bus.s1_ppn   = w_s1_page.ppn;
   assign bus.s1_ps    = w_s1_ps;
   assign bus.s1_plv   = w_s1_page.plv;
   assign bus.s1_mat   = w_s1_page.mat;
   assign bus.s1_d     = w_s1_page.d;
   assign bus.s1_v     = w_s1_page.v;

   assign bus.r_e    = w_rd_ent.e;
   assign bus.r_g    = w_rd_ent.g;
   assign bus.r_vppn = w_rd_ent.vppn;
   assign bus.r_ps   = w_rd_ent.ps;
   assign bus.r_asid = w_rd_ent.asid;
   assign bus.r_ppn0 = w_rd_ent.p0.ppn;
   assign bus.r_plv0 = w_rd_ent.p0.plv;
   assign bus.r_mat0 = w_rd_ent.p0.mat;
   assign bus.r_d0   = w_rd_ent.p0.d;
   assign bus.r_v0   = w_rd_ent.p0.v;
   assign bus.r_ppn1 = w_rd_ent.p1.ppn;
   assign bus.r_plv1 = w_rd_ent.p1.plv;
   assign bus.r_mat1 = w_rd_ent.p1.mat;
   assign bus.r_d1   = w_rd_ent.p1.d;
   assign bus.r_v1   = w_rd_ent.p1.v;

   assign bus.fill_index = r_fill;

endmodule
